uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. The data width, stop-bit count and baud-divisor width are set by parameters. Per-frame parity (odd/even) is available as a compile-time option. Data and divisor are latched at frame start, so the block supports back-to-back streaming. It sits behind the APB register wrapper and drives the serial Tx pin. One clock; the baud rate is derived internally from Load_Value.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
DIV_W, 10, width of the baud divisor Load_Value.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
tx_en  input  1  level request; a frame is accepted on any rising edge where the FSM is IDLE and tx_en=1.
data  input  DATA_W  frame payload; sampled only at accept.
Load_Value  input  DIV_W  bit period minus one, in clk cycles; sampled only at accept.
parity_odd  input  1  1 = odd parity, 0 = even; sampled at accept; ignored unless UART_TXP_PARITY_EN is defined.
Tx  output  1  serial line; idle high.
done  output  1  one-cycle pulse at frame completion.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, Tx=1, busy=0, done=0, all counters 0. Reset overrides everything.
- Reset during a frame aborts it: Tx=1 from the next edge, no done pulse.
- Bit period T = Load_Value+1 cycles. Load_Value=0 gives 1 cycle per bit. Maximum T is 2^DIV_W.
- A cycle counter counts 0..Load_Value (latched copy), then wraps to 0 and advances the bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: Tx=1, busy=0. On tx_en=1, at the same edge:
  - latch data, Load_Value and parity_odd;
  - go to START;
  - Tx=0 and busy=1 take effect from that edge.
- START: lasts T cycles, then DATA with bit index 0.
- DATA: Tx = latched data[idx], LSB first. Each bit lasts T cycles. After idx=DATA_W-1, go to PARITY if enabled, else STOP.
- PARITY: Tx = XOR of latched data, XORed with parity_odd. Lasts T cycles, then STOP.
- STOP: Tx=1 for STOP_BITS*T cycles, then IDLE.
- At the edge entering IDLE: done=1 for exactly one cycle and busy=0 in the same cycle.
- Frame length from the accept edge to the done edge is (1+DATA_W+P+STOP_BITS)*T cycles, where P=1 with parity and 0 without.
- Streaming: the done cycle is an IDLE cycle. If tx_en=1 during it, the next frame is accepted at the following edge. Tx stays 1 in the done cycle, giving one idle cycle between frames.
- Changes to data, Load_Value or parity_odd during a frame have no effect on that frame.
- tx_en during a frame is ignored; there is no queuing.
- Tx is driven from a register: no combinational path from inputs to Tx.

Optional Feature:
- Macro UART_TXP_PARITY_EN.
- Defined: the PARITY state is inserted after the data bits, as specified above, and parity_odd is honoured.
- Not defined: PARITY state and parity logic are compiled out, parity_odd is left unconnected internally, and P=0.

Test Plan:
- Basic frame. DATA_W=8, STOP_BITS=1, no parity, Load_Value=9, data=8'h35, tx_en pulsed for 1 cycle. Tx per 10-cycle period must be 0,1,0,1,0,1,1,0,0,1. busy=1 for 100 cycles. done is one cycle at accept+100. Tx=1 afterwards.
- Parity. UART_TXP_PARITY_EN defined, data=8'h35 (four ones), Load_Value=3.
  - parity_odd=0: parity bit 0, done at accept+44.
  - parity_odd=1: parity bit 1.
- Fastest rate, two stop bits. Load_Value=0, STOP_BITS=2, data=8'hFF. Tx = one 0 then ten 1s, one cycle each. done at accept+11.
- Streaming. tx_en held high, data=8'hA5 then 8'h5A, changed mid-frame 1. Frame 1 must carry A5 unchanged. Frame 2 (5A) starts the edge after done. Exactly one Tx=1 idle cycle between the frames' stop and start bits.
- Reset mid-frame. rst=1 for 1 cycle during data bit 3. Next cycle: Tx=1, busy=0; no done pulse. A new tx_en then sends a complete correct frame.
- Width. DATA_W=5, data=5'b10011, Load_Value=1. Tx = 0,1,1,0,0,1,1, two cycles per bit. done at accept+14.

Source files
------------

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised serial transmitter. Each frame is a start bit (0), DATA_W data
// bits sent LSB first, an optional parity bit, and STOP_BITS stop bits (1).
// The bit period is Load_Value+1 clock cycles. Data, divisor and parity
// selection are captured when a frame is accepted, so callers may change them
// freely while a frame is in flight and may stream frames back to back.
//
// Compile-time option:
//   UART_TXP_PARITY_EN  when defined, a parity bit (even or odd according to
//                       parity_odd) is inserted after the data bits. When not
//                       defined the parity state and logic do not exist.
//
// Parameters:
//   DATA_W     data bits per frame (5..9)
//   STOP_BITS  stop bits per frame (1 or 2)
//   DIV_W      width of Load_Value
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   tx_en       frame request, accepted when idle
//   data        frame payload, sampled at accept
//   Load_Value  bit period minus one in clk cycles, sampled at accept
//   parity_odd  1 = odd parity, 0 = even, sampled at accept
//   Tx          serial output, idle high, registered
//   done        one-cycle pulse on the edge that returns to idle
//   busy        high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic [DATA_W-1:0] data,
    input  logic [DIV_W-1:0]  Load_Value,
    input  logic              parity_odd,
    output logic              Tx,
    output logic              done,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    // Stop-bit index of the final stop bit: 0 for one stop bit, 1 for two.
    localparam logic STOP_LAST = (STOP_BITS == 2);

`ifdef UART_TXP_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  lv_q;
    logic [IDX_W-1:0]  idx;
    logic              stop_idx;
    logic [DATA_W-1:0] shreg;
    logic              tx_q;
    logic              done_q;
    logic              busy_q;
    logic              accept;
    logic              bit_end;
    logic              shift_en;

`ifdef UART_TXP_PARITY_EN
    logic              par_q;
`else
    // parity_odd has no function in this build.
    logic              unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign accept  = (state == IDLE) && tx_en;
    assign bit_end = (cnt == lv_q);

    // The shift register presents the next data bit at bit 0; it advances on
    // every bit boundary where a data bit is about to be loaded into Tx.
    assign shift_en = bit_end &&
                      ((state == START) || ((state == DATA) && (idx != IDX_LAST)));

    // Frame payload and divisor capture; pure datapath, not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= data;
            lv_q  <= Load_Value;
`ifdef UART_TXP_PARITY_EN
            par_q <= (^data) ^ parity_odd;
`endif
        end else if (shift_en) begin
            shreg <= shreg >> 1;
        end
    end

    // Frame sequencer with registered Tx/busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    if (tx_en) begin
                        state  <= START;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end

                START: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end) begin
                        state <= DATA;
                        idx   <= '0;
                        tx_q  <= shreg[0];
                    end
                end

                DATA: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end) begin
                        if (idx == IDX_LAST) begin
`ifdef UART_TXP_PARITY_EN
                            state <= PARITY;
                            tx_q  <= par_q;
`else
                            state    <= STOP;
                            tx_q     <= 1'b1;
                            stop_idx <= 1'b0;
`endif
                        end else begin
                            idx  <= idx + 1'b1;
                            tx_q <= shreg[0];
                        end
                    end
                end

`ifdef UART_TXP_PARITY_EN
                PARITY: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end) begin
                        state    <= STOP;
                        tx_q     <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end
`endif

                STOP: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end) begin
                        if (stop_idx == STOP_LAST) begin
                            // Returning to idle: this cycle is the done cycle.
                            state  <= IDLE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            tx_q   <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    assign Tx   = tx_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule
